histogram_frame_sequencer: RTL

- Per-frame controller for the auto-threshold pipeline.
- Each frame it zeroes the histogram RAM, gates the pixel accumulator for exactly one frame, and lets the accumulator's read-modify-write (RMW) pipeline drain.
- It then kicks the cumulative-histogram engine, waits for its done flag, acknowledges it, and publishes threshold/max results to the LCD scaling logic.
- Sits between the camera capture timing (frame start/end strobes) and the histogram/cumulative-histogram RAM datapath.

---
 rtl/histogram_frame_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/histogram_frame_sequencer.sv
// histogram_frame_sequencer
// Per-frame controller for the auto-threshold pipeline. Each frame: clear the
// histogram RAM, grant it to the pixel accumulator for one frame, let the
// accumulator RMW pipeline drain, run the cumulative-histogram engine, and
// publish its threshold/max results.
module histogram_frame_sequencer #(
  parameter int WORD_SIZE    = 20,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEnable,
  input  logic                 iFrameStart,
  input  logic                 iFrameEnd,
  output logic                 oHistClrWE,
  output logic [7:0]           oHistClrAddr,
  output logic [WORD_SIZE-1:0] oHistClrData,
  output logic                 oAccumEn,
  output logic                 oCumStart,
  output logic                 oCumRestart,
  input  logic                 iCumDone,
  input  logic [7:0]           iCumThreshold,
  input  logic [19:0]          iCumMaxValue,
  output logic [7:0]           oThreshold,
  output logic [19:0]          oMaxValue,
  output logic                 oResultValid,
  output logic                 oBusy,
  output logic [7:0]           oFramesDropped,
  output logic                 oTimeout
);

  localparam int DCW = $clog2(DRAIN_CYCLES) + 1;
  localparam int TCW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARMED,
    S_ACCUM,
    S_DRAIN,
    S_START_CUM,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t           r_state;
  logic             r_clr_we;
  logic [7:0]       r_clr_addr;
  logic             r_accum_en;
  logic             r_cum_start;
  logic             r_cum_restart;
  logic [7:0]       r_threshold;
  logic [19:0]      r_max_value;
  logic             r_result_valid;
  logic             r_busy;
  logic [7:0]       r_frames_dropped;
  logic             r_timeout;
  logic [DCW-1:0]   r_drain_cnt;
  logic [TCW-1:0]   r_wait_cnt;

  // Sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state          <= S_IDLE;
      r_clr_we         <= 1'b0;
      r_clr_addr       <= 8'd0;
      r_accum_en       <= 1'b0;
      r_cum_start      <= 1'b0;
      r_cum_restart    <= 1'b0;
      r_threshold      <= 8'd0;
      r_max_value      <= 20'd0;
      r_result_valid   <= 1'b0;
      r_busy           <= 1'b0;
      r_frames_dropped <= 8'd0;
      r_timeout        <= 1'b0;
      r_drain_cnt      <= '0;
      r_wait_cnt       <= '0;
    end else begin
      // Single-cycle strobes fall back low unless re-asserted below
      r_cum_start    <= 1'b0;
      r_cum_restart  <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iEnable) begin
            r_state    <= S_CLEAR;
            r_clr_we   <= 1'b1;
            r_clr_addr <= 8'd0;
            r_busy     <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (iFrameStart && (r_frames_dropped != 8'hFF))
            r_frames_dropped <= r_frames_dropped + 8'd1;
          // Natural 8-bit wrap leaves the address at 0 for the next clear
          r_clr_addr <= r_clr_addr + 8'd1;
          if (r_clr_addr == 8'hFF) begin
            r_clr_we <= 1'b0;
            r_state  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (iFrameStart) begin
            r_state    <= S_ACCUM;
            r_accum_en <= 1'b1;
          end else if (!iEnable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_ACCUM: begin
          // End of frame takes priority over a coincident start
          if (iFrameEnd) begin
            r_accum_en  <= 1'b0;
            r_drain_cnt <= '0;
            r_state     <= S_DRAIN;
          end else if (iFrameStart && (r_frames_dropped != 8'hFF)) begin
            r_frames_dropped <= r_frames_dropped + 8'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
            r_state     <= S_START_CUM;
            r_cum_start <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_START_CUM: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (iCumDone) begin
            r_threshold    <= iCumThreshold;
            r_max_value    <= iCumMaxValue;
            r_cum_restart  <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_ACK;
          end else if (r_wait_cnt == TCW'(TIMEOUT - 1)) begin
            r_timeout     <= 1'b1;
            r_cum_restart <= 1'b1;
            r_state       <= S_ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_ACK: begin
          if (iEnable) begin
            r_state    <= S_CLEAR;
            r_clr_we   <= 1'b1;
            r_clr_addr <= 8'd0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oHistClrWE     = r_clr_we;
  assign oHistClrAddr   = r_clr_addr;
  assign oHistClrData   = '0;
  assign oAccumEn       = r_accum_en;
  assign oCumStart      = r_cum_start;
  assign oCumRestart    = r_cum_restart;
  assign oThreshold     = r_threshold;
  assign oMaxValue      = r_max_value;
  assign oResultValid   = r_result_valid;
  assign oBusy          = r_busy;
  assign oFramesDropped = r_frames_dropped;
  assign oTimeout       = r_timeout;

endmodule
